// File: rtl/vector_mac_ctrl.sv
// vector_mac_ctrl: sequences N operand beats through an external VECTOR-lane MAC, feeding back accumulators.
// Optional build macro VMAC_CTRL_BIAS_EN adds the cmd_bias port for per-lane initial accumulators.
module vector_mac_ctrl #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [LEN_WIDTH-1:0]            cmd_len,
`ifdef VMAC_CTRL_BIAS_EN
    input  logic [VECTOR*REG_WIDTH-1:0]     cmd_bias,
`endif
    input  logic                            op_valid,
    output logic                            op_ready,
    input  logic [VECTOR*REG_WIDTH-1:0]     op_a,
    input  logic [VECTOR*REG_WIDTH-1:0]     op_b,
    output logic [VECTOR*REG_WIDTH-1:0]     mac_a,
    output logic [VECTOR*REG_WIDTH-1:0]     mac_b,
    output logic [VECTOR*2*REG_WIDTH-1:0]   mac_c,
    input  logic [VECTOR*REG_WIDTH-1:0]     mac_res,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [VECTOR*REG_WIDTH-1:0]     res_data,
    output logic                            busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state;
    logic [VECTOR*REG_WIDTH-1:0] acc;
    logic [VECTOR*REG_WIDTH-1:0] init;
    logic [LEN_WIDTH-1:0]        remaining;

`ifdef VMAC_CTRL_BIAS_EN
    assign init = cmd_bias;
`else
    assign init = '0;
`endif

    assign mac_a    = op_a;
    assign mac_b    = op_b;
    assign res_data = acc;

    for (genvar j = 0; j < VECTOR; j++) begin : g_lane
        assign mac_c[j*2*REG_WIDTH +: 2*REG_WIDTH] = {{REG_WIDTH{1'b0}}, acc[j*REG_WIDTH +: REG_WIDTH]};
    end

    // Command/beat/result sequencer; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            cmd_ready <= 1'b1;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    acc       <= init;
                    remaining <= cmd_len;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (cmd_len != '0) begin
                        state    <= RUN;
                        op_ready <= 1'b1;
                    end else begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                RUN: if (op_valid) begin
                    acc       <= mac_res;
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_WIDTH'(1)) begin
                        state     <= DONE;
                        op_ready  <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: if (res_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    op_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_mac_ctrl.sv
// tb_vector_mac_ctrl: randomized and directed checks of vector_mac_ctrl against a per-lane dot-product model.
module tb_vector_mac_ctrl;
    localparam int W  = 16;
    localparam int V  = 8;
    localparam int L  = 8;
    localparam int DW = W * V;

    logic            clk = 0;
    logic            rst_n = 1;
    logic            cmd_valid = 0;
    logic            cmd_ready;
    logic [L-1:0]    cmd_len = '0;
    logic [DW-1:0]   cmd_bias = '0;
    logic            op_valid = 0;
    logic            op_ready;
    logic [DW-1:0]   op_a = '0;
    logic [DW-1:0]   op_b = '0;
    logic [DW-1:0]   mac_a;
    logic [DW-1:0]   mac_b;
    logic [2*DW-1:0] mac_c;
    logic [DW-1:0]   mac_res;
    logic            res_valid;
    logic            res_ready = 0;
    logic [DW-1:0]   res_data;
    logic            busy;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit            vpat[$];
    bit            rand_stall = 0;
    logic [DW-1:0] last_res;

    always #5 clk = ~clk;

    vector_mac_ctrl #(.REG_WIDTH(W), .VECTOR(V), .LEN_WIDTH(L)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
`ifdef VMAC_CTRL_BIAS_EN
        .cmd_bias(cmd_bias),
`endif
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_a(op_a),
        .op_b(op_b),
        .mac_a(mac_a),
        .mac_b(mac_b),
        .mac_c(mac_c),
        .mac_res(mac_res),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .busy(busy)
    );

    // External MAC array: c + a*b truncated to W bits per lane.
    always_comb begin
        mac_res = '0;
        for (int j = 0; j < V; j++)
            mac_res[j*W +: W] = W'(mac_a[j*W +: W] * mac_b[j*W +: W] + mac_c[j*2*W +: 2*W]);
    end

    task automatic check(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v;
        for (int j = 0; j < V; j++) v[j*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [DW-1:0] splat(input logic [W-1:0] x);
        logic [DW-1:0] v;
        for (int j = 0; j < V; j++) v[j*W +: W] = x;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_op_ready"}, op_ready, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_data"}, res_data, 0);
    endtask

    // One command: n beats, rr_wait cycles of result backpressure, optional reset after abort_at beats.
    task automatic run_cmd(input int n, input int rr_wait, input int abort_at);
        longint        lane[V];
        logic [DW-1:0] av, bv, exp, lo, hi;
        int            got, cyc;
        bit            v, need;
        for (int j = 0; j < V; j++) begin
`ifdef VMAC_CTRL_BIAS_EN
            lane[j] = longint'(cmd_bias[j*W +: W]);
`else
            lane[j] = 0;
`endif
        end
        op_valid = 1;
        op_a = rnd_vec();
        op_b = rnd_vec();
        cmd_valid = 1;
        cmd_len = L'(n);
        #1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_op_ready", op_ready, 0);
        @(posedge clk); #1;
        cmd_valid = 0;
        op_valid = 0;
        check("accept_busy", busy, 1);
        check("accept_cmd_ready", cmd_ready, 0);
        got = 0;
        cyc = 0;
        need = 1;
        while (got < n) begin
            if (cyc > 8 * n + 50) begin
                check("beat_timeout", got, n);
                break;
            end
            if (need) begin
                av = qa.size() != 0 ? qa.pop_front() : rnd_vec();
                bv = qb.size() != 0 ? qb.pop_front() : rnd_vec();
                need = 0;
            end
            v = vpat.size() != 0 ? vpat.pop_front() : (rand_stall ? 1'($urandom_range(0, 1)) : 1'b1);
            op_a = av;
            op_b = bv;
            op_valid = v;
            #1;
            for (int j = 0; j < V; j++) begin
                exp[j*W +: W] = W'(lane[j]);
                lo[j*W +: W]  = mac_c[j*2*W +: W];
                hi[j*W +: W]  = mac_c[j*2*W+W +: W];
            end
            check("run_op_ready", op_ready, 1);
            check("run_res_valid", res_valid, 0);
            check("mac_a", mac_a, av);
            check("mac_b", mac_b, bv);
            check("mac_c_lo", lo, exp);
            check("mac_c_hi", hi, 0);
            @(posedge clk); #1;
            if (v) begin
                for (int j = 0; j < V; j++)
                    lane[j] = (lane[j] + longint'(av[j*W +: W]) * longint'(bv[j*W +: W])) % 65536;
                got++;
                need = 1;
                if (got == abort_at) begin
                    rst_n = 0;
                    #1;
                    check_reset_outputs("abort");
                    #3;
                    rst_n = 1;
                    op_valid = 0;
                    return;
                end
            end
            cyc++;
        end
        for (int j = 0; j < V; j++) exp[j*W +: W] = W'(lane[j]);
        op_valid = 1;
        op_a = rnd_vec();
        op_b = rnd_vec();
        check("done_res_valid", res_valid, 1);
        check("done_op_ready", op_ready, 0);
        for (int k = 0; k < rr_wait; k++) begin
            @(posedge clk); #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        check("res_data", res_data, exp);
        last_res = res_data;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        op_valid = 0;
        check("post_res_valid", res_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] e;
        #1 rst_n = 0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        cmd_bias = '0;
        qa.push_back(splat(2)); qb.push_back(splat(3));
        qa.push_back(splat(1)); qb.push_back(splat(5));
        qa.push_back(splat(4)); qb.push_back(splat(4));
        run_cmd(3, 0, -1);
        check("basic_27", last_res, splat(27));

        cmd_bias = rnd_vec();
        run_cmd(0, 1, -1);

        cmd_bias = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < V; j++) e[j*W +: W] = W'(j);
            qa.push_back(e);
            qb.push_back(splat(1));
        end
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        run_cmd(4, 5, -1);
        for (int j = 0; j < V; j++) e[j*W +: W] = W'(4 * j);
        check("stall_4j", last_res, e);

`ifdef VMAC_CTRL_BIAS_EN
        cmd_bias = splat(16'hFFF0);
        qa.push_back(splat(4)); qb.push_back(splat(8));
        run_cmd(1, 0, -1);
        check("wrap_bias", last_res, splat(16'h0010));
`endif

        cmd_bias = '0;
        run_cmd(5, 0, 2);
        @(posedge clk); #1;
        qa.push_back(splat(1)); qb.push_back(splat(1));
        run_cmd(1, 0, -1);
        check("after_reset", last_res, splat(1));

        run_cmd(2, 0, -1);
        run_cmd(2, 0, -1);

        cmd_bias = rnd_vec();
        run_cmd(255, 0, -1);

        rand_stall = 1;
        for (int t = 0; t < 20; t++) begin
            cmd_bias = rnd_vec();
            run_cmd($urandom_range(0, 12), $urandom_range(0, 3), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vector_mac_ctrl.md
# vector_mac_ctrl

Sequencer for the integer vector MAC datapath (`VECTOR` lanes of `a*b+c`, `REG_WIDTH`-bit results). Accepts a command giving a dot-product length in beats and streams that many operand vectors through the MAC. Feeds each lane's accumulator back as the MAC `c` input and presents the finished `VECTOR`-lane result on a valid/ready output. Sits between the operand-fetch logic and the MAC array; the MAC itself is instantiated outside this block.

## Interface
- `REG_WIDTH`, 16, operand and accumulator width per lane
- `VECTOR`, 8, number of lanes
- `LEN_WIDTH`, 8, width of the beat-count field
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_len`  in  `LEN_WIDTH`  number of operand beats N; 0 is legal
- `cmd_bias`  in  `REG_WIDTH` x `VECTOR`  per-lane initial accumulator; port exists only when `VMAC_CTRL_BIAS_EN` is defined
- `op_valid` / `op_ready`  in/out  1  operand-beat handshake
- `op_a`, `op_b`  in  `REG_WIDTH` x `VECTOR`  operand vectors
- `mac_a`, `mac_b`  out  `REG_WIDTH` x `VECTOR`  to MAC; combinational pass-through of `op_a` and `op_b`
- `mac_c`  out  `2*REG_WIDTH` x `VECTOR`  to MAC; zero-extended accumulator
- `mac_res`  in  `REG_WIDTH` x `VECTOR`  combinational MAC result `c_ab`
- `res_valid` / `res_ready`  out/in  1  result handshake
- `res_data`  out  `REG_WIDTH` x `VECTOR`  final accumulators
- `busy`  out  1  high in any state other than IDLE

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **IDLE:**
  - `cmd_ready`=1.
  - On the `cmd_valid`&`cmd_ready` edge, load `acc[j]` with the init value and load `remaining` with `cmd_len`.
  - Go to RUN if `cmd_len`≠0; otherwise go to DONE.
- **RUN:**
  - `op_ready`=1.
  - On each `op_valid` edge: `acc[j]` <= `mac_res[j]` for every lane, and `remaining` decrements.
  - When the accepted beat has `remaining`==1, go to DONE.
  - With `op_valid`=0, nothing changes; stalls of any length are legal.
- **DONE:**
  - `res_valid`=1 and `res_data`=`acc`, held stable until the handshake completes.
  - On `res_ready`, go to IDLE.
- **Ready outside the owning state:** `cmd_ready`=0 outside IDLE and `op_ready`=0 outside RUN. Operand beats presented in any state other than RUN are ignored.
- **Arithmetic:**
  - Per-lane result is modulo 2^`REG_WIDTH` (MAC output width); wrap is silent.
  - `mac_c` upper `REG_WIDTH` bits are 0.
- `res_data` is driven from `acc` in all states; it is only meaningful while `res_valid`=1.

## Timing
- **Reset values (asserted asynchronously):**
  - state=IDLE, `acc`=0, `remaining`=0.
  - `res_valid`=0, `op_ready`=0, `busy`=0.
  - `cmd_ready`=1 (decoded from IDLE).
  - `res_data`=0.
- Reset mid-RUN or mid-DONE aborts immediately. The partial result is lost and no `res_valid` is produced.
- **Latency:**
  - Command accepted at edge 0.
  - With `op_valid` held high, beats are accepted at edges 1..N.
  - `res_valid` rises after edge N, i.e. the cycle after the last beat handshake.
  - For N=0, `res_valid` rises the cycle after the command handshake.
- **Throughput:** one beat per cycle in RUN. Minimum command-to-command spacing is N+2 cycles with `res_ready` held high.
- If `res_ready`=1 when `res_valid` rises, the handshake completes on that edge. The block then returns to IDLE and can accept a command the following cycle.
- `cmd_len`=2^`LEN_WIDTH`-1 is the maximum; `remaining` never underflows.
- All outputs except `mac_a`, `mac_b` and `mac_c` are registered or decoded from state only. There are no combinational paths from `*_valid` to `*_ready`.

## Configuration
- Macro: `VMAC_CTRL_BIAS_EN`.
- **Defined:** the `cmd_bias` port exists, and `acc[j]` loads `cmd_bias[j]` at command accept.
- **Undefined:** no `cmd_bias` port, and `acc[j]` loads 0 at command accept.
- All other behaviour is identical in both builds.

## Test plan
- **Basic dot product.** Build: macro off, `VECTOR`=8. Stimulus: N=3, all lanes get a=2,b=3 then a=1,b=5 then a=4,b=4, `op_valid` held high. Required: `res_data`=27 on every lane; `res_valid` rises the cycle after the third beat.
- **Zero length.** Stimulus: N=0. Required: `res_valid` the cycle after the command handshake with `res_data`=0 (macro off) or `cmd_bias` (macro on); `op_ready` never asserts.
- **Stalls and backpressure.** Stimulus: N=4, `op_valid` toggling 1,0,0,1,1,0,1 with lane j operands a=j, b=1; `res_ready` held low for 5 cycles. Required: `res_data[j]`=4j, held stable and `res_valid` high for all 5 cycles; the block returns to IDLE only on the `res_ready` edge.
- **Wrap and bias.** Build: macro on. Stimulus: `cmd_bias`=16'hFFF0, N=1, a=4, b=8. Required: `res_data`=16'h0010 on every lane.
- **Reset mid-RUN.** Stimulus: N=5, drop `rst_n` after beat 2. Required: all outputs at reset values immediately; the next command N=1 with a=b=1 yields 1 per lane.
- **Back-to-back commands.** Stimulus: two commands, N=2 each, `res_ready`=1. Required: the second `cmd_ready` handshake occurs the cycle after the first result handshake; `op_valid` beats presented during DONE/IDLE are not consumed (`op_ready`=0).
